crypto_core_arbiter: RTL
========================

Name: crypto_core_arbiter

Overview:
- Shares one crypto accelerator core between NUM_REQ requesters (CPU MMIO path, DMA, etc.) in the RISC-V crypto SoC.
- Round-robin arbitration; sequences the core's start/done handshake for the granted requester.
- Returns a one-cycle completion pulse to the owner, then releases the core.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of Grant_id; must equal ceil(log2(NUM_REQ)).
- TIMEOUT_CYCLES, 1024, watchdog limit in RUN cycles; used only with the optional feature.
- CNT_W, 16, watchdog counter width; must be able to hold TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock, all logic on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Req_in  in  NUM_REQ  per-requester request level; held until the matching Done_out.
- Grant_out  out  NUM_REQ  one-hot owner of the core; all zero when the core is free.
- Grant_id  out  ID_W  binary index of the current owner.
- Done_out  out  NUM_REQ  one-cycle completion pulse to the owner.
- Core_start  out  1  one-cycle start pulse to the core.
- Core_done  in  1  completion from the core; sampled only in RUN.
- Busy  out  1  high from GRANT through DONE.
- Timeout_flag  out  1  sticky flag: the last operation was aborted by the watchdog.

Behaviour:
- One clock; reset is asynchronous and active-high (CLK, RST).
- Reset values:
  - state IDLE.
  - Grant_out=0, Grant_id=0, Done_out=0, Core_start=0, Busy=0, Timeout_flag=0.
  - Round-robin pointer=0 (requester 0 has highest priority). Watchdog counter=0.
- Asserting RST mid-operation forces all of the above immediately. No Done_out is issued for the aborted operation.
- All outputs are registered.
- State IDLE:
  - If any Req_in bit is set at an edge, select the first set bit, searching from the pointer upward with wrap to 0.
  - At that edge: Grant_out=onehot(sel), Grant_id=sel, Busy=1, pointer=(sel+1) mod NUM_REQ, go to GRANT.
  - If no request, stay in IDLE with outputs unchanged.
- State GRANT (one cycle):
  - Core_start=1 for this cycle only; clear Timeout_flag and the watchdog counter; go to RUN.
  - Latency: request sampled at edge t gives Grant_out high from t, and Core_start high during cycle t+1.
- State RUN:
  - Core_start=0. Wait for Core_done=1.
  - On the edge where Core_done=1: Done_out=onehot(Grant_id), go to DONE.
- State DONE (one cycle):
  - Done_out pulse is visible here.
  - At the next edge: Done_out=0, Grant_out=0, Busy=0, go to IDLE.
  - Grant_id keeps its last value.
- Requester rule: deassert Req_in no later than the edge that ends the DONE cycle. A request still high in IDLE is treated as a new request.
- Boundary cases:
  - Core_done in IDLE, GRANT or DONE: ignored, no output change.
  - Core_done held high across operations: only the RUN-state sample counts, giving one Done_out per operation.
  - Owner drops Req_in during GRANT or RUN: the operation still completes and Done_out still pulses.
  - Non-owner Req_in changes during an operation: no effect until IDLE.
  - Pointer wrap: granting requester NUM_REQ-1 sets the pointer to 0.
  - Simultaneous requests: exactly one grant per operation; the others wait without loss.

Optional Feature:
- Macro: CRYPTO_ARB_TIMEOUT_EN.
- Defined:
  - The watchdog counter increments every RUN cycle.
  - If it reaches TIMEOUT_CYCLES with no Core_done, go to DONE and pulse Done_out for the owner as normal.
  - Set Timeout_flag=1; it holds until the next GRANT.
  - If Core_done and the limit occur on the same edge, Core_done wins and Timeout_flag stays 0.
- Not defined:
  - Timeout_flag is tied to 0, the counter is absent, and RUN waits indefinitely for Core_done.

Test Plan:
- Single request: Req_in=0001 at edge t.
  - Grant_out=0001 and Busy=1 from t; Core_start=1 in cycle t+1 only.
  - Core_done high 5 cycles later gives Done_out=0001 for exactly 1 cycle, then Grant_out=0000 and Busy=0.
- Fairness: Req_in=1111, each requester re-asserting after its Done_out.
  - Grant order is 0,1,2,3,0; Grant_id follows.
  - Each grant starts 1 cycle after the previous DONE.
- Sparse requests: after a grant to 0, Req_in=0101.
  - Next grant is 2, then 0. Requesters 1 and 3 are never granted.
- Stray and held done: Core_done pulsed in IDLE and in GRANT causes no output change.
  - Core_done held high across two operations gives exactly one Done_out per operation.
- Reset mid-RUN: RST asserted while Grant_out=0100.
  - All outputs go to 0 without waiting for an edge; no Done_out; after release with Req_in=1111 the first grant is to 0.
- Watchdog (macro defined, TIMEOUT_CYCLES=16): Core_done never asserts.
  - Done_out pulses for the owner 16 cycles after RUN entry, Timeout_flag=1.
  - Timeout_flag clears in the next GRANT.

Source files
------------

// File: rtl/crypto_core_arbiter_if.sv
// Request/grant/completion bundle between the requesters, the shared crypto core and the arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/core side.
interface crypto_core_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0] Req_in;
    logic [NUM_REQ-1:0] Grant_out;
    logic [ID_W-1:0]    Grant_id;
    logic [NUM_REQ-1:0] Done_out;
    logic               Core_start;
    logic               Core_done;
    logic               Busy;
    logic               Timeout_flag;

    modport slave (
        input  Req_in, Core_done,
        output Grant_out, Grant_id, Done_out, Core_start, Busy, Timeout_flag
    );

    modport master (
        output Req_in, Core_done,
        input  Grant_out, Grant_id, Done_out, Core_start, Busy, Timeout_flag
    );
endinterface

// File: rtl/crypto_core_arbiter.sv
// Round-robin owner selection for one shared crypto core, sequencing start/done for the owner.
// Define CRYPTO_ARB_TIMEOUT_EN to add a RUN-state watchdog that aborts a hung operation.
module crypto_core_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    crypto_core_arbiter_if.slave  bus
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_params
        $error("crypto_core_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [NUM_REQ-1:0] done_reg, done_next;
    logic [ID_W-1:0]    id_reg, id_next;
    logic [ID_W-1:0]    ptr_reg, ptr_next;
    logic               start_reg, start_next;
    logic               busy_reg, busy_next;

    logic               sel_found;
    logic [ID_W-1:0]    sel_idx;
    logic [ID_W-1:0]    scan_idx;
    logic [NUM_REQ-1:0] sel_onehot;

`ifdef CRYPTO_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               tflag_reg, tflag_next;
`endif

    // Scan from the highest offset down so the lowest offset from the pointer wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (int'(ptr_reg) + k >= NUM_REQ)
                scan_idx = ID_W'(int'(ptr_reg) + k - NUM_REQ);
            else
                scan_idx = ID_W'(int'(ptr_reg) + k);
            if (bus.Req_in[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel_onehot
        assign sel_onehot[gi] = (sel_idx == ID_W'(gi));
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        id_next    = id_reg;
        done_next  = '0;
        start_next = 1'b0;
        busy_next  = busy_reg;
        ptr_next   = ptr_reg;
`ifdef CRYPTO_ARB_TIMEOUT_EN
        cnt_next   = cnt_reg;
        tflag_next = tflag_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    grant_next = sel_onehot;
                    id_next    = sel_idx;
                    busy_next  = 1'b1;
                    start_next = 1'b1;
                    ptr_next   = (sel_idx == ID_W'(NUM_REQ - 1)) ? '0 : sel_idx + ID_W'(1);
                    state_next = GRANT;
`ifdef CRYPTO_ARB_TIMEOUT_EN
                    cnt_next   = '0;
                    tflag_next = 1'b0;
`endif
                end
            end
            GRANT: state_next = RUN;
            RUN: begin
                // A real completion on the limit edge beats the watchdog.
                if (bus.Core_done) begin
                    done_next  = grant_reg;
                    state_next = DONE;
                end
`ifdef CRYPTO_ARB_TIMEOUT_EN
                else if (cnt_reg == LIMIT) begin
                    done_next  = grant_reg;
                    tflag_next = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            DONE: begin
                grant_next = '0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            done_reg  <= '0;
            id_reg    <= '0;
            ptr_reg   <= '0;
            start_reg <= 1'b0;
            busy_reg  <= 1'b0;
`ifdef CRYPTO_ARB_TIMEOUT_EN
            cnt_reg   <= '0;
            tflag_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            done_reg  <= done_next;
            id_reg    <= id_next;
            ptr_reg   <= ptr_next;
            start_reg <= start_next;
            busy_reg  <= busy_next;
`ifdef CRYPTO_ARB_TIMEOUT_EN
            cnt_reg   <= cnt_next;
            tflag_reg <= tflag_next;
`endif
        end
    end

    assign bus.Grant_out  = grant_reg;
    assign bus.Grant_id   = id_reg;
    assign bus.Done_out   = done_reg;
    assign bus.Core_start = start_reg;
    assign bus.Busy       = busy_reg;
`ifdef CRYPTO_ARB_TIMEOUT_EN
    assign bus.Timeout_flag = tflag_reg;
`else
    assign bus.Timeout_flag = 1'b0;
`endif

endmodule
